// File: rtl/sudoku_grid_checker.sv
// Streams 81 row-major sudoku cells and reports one solved/incomplete/conflict verdict per frame.
// Optional macro CHECKER_FIRST_CONFLICT_EN records the position of the first offending cell.
module sudoku_grid_checker (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    output logic       in_ready,
    output logic       done,
    output logic       solved,
    output logic       conflict,
    output logic       illegal,
    output logic [6:0] empty_count,
    output logic [3:0] conflict_row,
    output logic [3:0] conflict_col
);
    localparam logic [3:0] EMPTY_CODE = 4'd0;

    localparam logic [1:0] ST_CLEAR   = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0] state_q, state_d;
    logic       in_ready_q, in_ready_d;
    logic       done_q, done_d;
    logic [3:0] r_q, r_d, c_q, c_d;
    logic [8:0] row_mask_q [9];
    logic [8:0] row_mask_d [9];
    logic [8:0] col_mask_q [9];
    logic [8:0] col_mask_d [9];
    logic [8:0] box_mask_q [9];
    logic [8:0] box_mask_d [9];
    logic       conflict_run_q, conflict_run_d;
    logic       illegal_run_q, illegal_run_d;
    logic [6:0] empty_cnt_q, empty_cnt_d;
    logic       solved_q, solved_d;
    logic       conflict_q, conflict_d;
    logic       illegal_q, illegal_d;
    logic [6:0] empty_count_q, empty_count_d;

    logic       accept;
    logic       legal;
    logic       seen;
    logic [3:0] box;
    logic [8:0] digit_bit;

    function automatic logic [3:0] third(input logic [3:0] v);
        if (v < 4'd3)      third = 4'd0;
        else if (v < 4'd6) third = 4'd1;
        else               third = 4'd2;
    endfunction

`ifdef CHECKER_FIRST_CONFLICT_EN
    logic       first_flag_q, first_flag_d;
    logic [3:0] first_row_q, first_row_d;
    logic [3:0] first_col_q, first_col_d;
    logic [3:0] conflict_row_q, conflict_row_d;
    logic [3:0] conflict_col_q, conflict_col_d;
`endif

    always_comb begin
        state_d        = state_q;
        r_d            = r_q;
        c_d            = c_q;
        row_mask_d     = row_mask_q;
        col_mask_d     = col_mask_q;
        box_mask_d     = box_mask_q;
        conflict_run_d = conflict_run_q;
        illegal_run_d  = illegal_run_q;
        empty_cnt_d    = empty_cnt_q;

        accept    = in_valid && in_ready_q;
        legal     = (in_digit >= 4'd1) && (in_digit <= 4'd9);
        box       = third(r_q) * 4'd3 + third(c_q);
        // EMPTY_CODE wraps the shift amount out of range; the bit is only used for legal digits.
        digit_bit = 9'd1 << (in_digit - 4'd1);
        seen      = |((row_mask_q[r_q] | col_mask_q[c_q] | box_mask_q[box]) & digit_bit);

        case (state_q)
            ST_CLEAR: begin
                for (int i = 0; i < 9; i++) begin
                    row_mask_d[i] = '0;
                    col_mask_d[i] = '0;
                    box_mask_d[i] = '0;
                end
                r_d            = '0;
                c_d            = '0;
                conflict_run_d = 1'b0;
                illegal_run_d  = 1'b0;
                empty_cnt_d    = '0;
                state_d        = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (accept) begin
                    if (in_digit == EMPTY_CODE) begin
                        empty_cnt_d = empty_cnt_q + 7'd1;
                    end else if (legal) begin
                        if (seen) conflict_run_d = 1'b1;
                        row_mask_d[r_q] = row_mask_q[r_q] | digit_bit;
                        col_mask_d[c_q] = col_mask_q[c_q] | digit_bit;
                        box_mask_d[box] = box_mask_q[box] | digit_bit;
                    end else begin
                        illegal_run_d = 1'b1;
                    end
                    if (c_q == 4'd8) begin
                        c_d = '0;
                        if (r_q == 4'd8) state_d = ST_DONE;
                        else             r_d = r_q + 4'd1;
                    end else begin
                        c_d = c_q + 4'd1;
                    end
                end
            end
            ST_DONE:  state_d = ST_CLEAR;
            default:  state_d = ST_CLEAR;
        endcase

        in_ready_d = (state_d == ST_COLLECT);
        done_d     = (state_d == ST_DONE);

        // Verdict loads on the edge entering DONE so the final cell is included.
        solved_d      = solved_q;
        conflict_d    = conflict_q;
        illegal_d     = illegal_q;
        empty_count_d = empty_count_q;
        if (state_d == ST_DONE) begin
            solved_d      = !conflict_run_d && !illegal_run_d && (empty_cnt_d == 7'd0);
            conflict_d    = conflict_run_d;
            illegal_d     = illegal_run_d;
            empty_count_d = empty_cnt_d;
        end
    end

`ifdef CHECKER_FIRST_CONFLICT_EN
    always_comb begin
        first_flag_d   = first_flag_q;
        first_row_d    = first_row_q;
        first_col_d    = first_col_q;
        conflict_row_d = conflict_row_q;
        conflict_col_d = conflict_col_q;
        if (state_q == ST_CLEAR) begin
            first_flag_d = 1'b0;
            first_row_d  = '0;
            first_col_d  = '0;
        end else if (!first_flag_q && (conflict_run_d || illegal_run_d)) begin
            first_flag_d = 1'b1;
            first_row_d  = r_q;
            first_col_d  = c_q;
        end
        if (state_d == ST_DONE) begin
            conflict_row_d = first_row_d;
            conflict_col_d = first_col_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            first_flag_q   <= 1'b0;
            first_row_q    <= '0;
            first_col_q    <= '0;
            conflict_row_q <= '0;
            conflict_col_q <= '0;
        end else begin
            first_flag_q   <= first_flag_d;
            first_row_q    <= first_row_d;
            first_col_q    <= first_col_d;
            conflict_row_q <= conflict_row_d;
            conflict_col_q <= conflict_col_d;
        end
    end

    assign conflict_row = conflict_row_q;
    assign conflict_col = conflict_col_q;
`else
    assign conflict_row = 4'd0;
    assign conflict_col = 4'd0;
`endif

    // NOTE: masks carry no reset; reset always passes through CLEAR, which zeroes them before use.
    always_ff @(posedge clk) begin
        row_mask_q <= row_mask_d;
        col_mask_q <= col_mask_d;
        box_mask_q <= box_mask_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_CLEAR;
            in_ready_q     <= 1'b0;
            done_q         <= 1'b0;
            r_q            <= '0;
            c_q            <= '0;
            conflict_run_q <= 1'b0;
            illegal_run_q  <= 1'b0;
            empty_cnt_q    <= '0;
            solved_q       <= 1'b0;
            conflict_q     <= 1'b0;
            illegal_q      <= 1'b0;
            empty_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            done_q         <= done_d;
            r_q            <= r_d;
            c_q            <= c_d;
            conflict_run_q <= conflict_run_d;
            illegal_run_q  <= illegal_run_d;
            empty_cnt_q    <= empty_cnt_d;
            solved_q       <= solved_d;
            conflict_q     <= conflict_d;
            illegal_q      <= illegal_d;
            empty_count_q  <= empty_count_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign done        = done_q;
    assign solved      = solved_q;
    assign conflict    = conflict_q;
    assign illegal     = illegal_q;
    assign empty_count = empty_count_q;

endmodule
